// File: rtl/clk_activity_monitor.sv
// N-channel clock-activity monitor: counts synchronized toggle edges per fixed window of clk
// cycles and qualifies each channel as toggling / too fast / lost, with acquire/loss hysteresis.
module clk_activity_monitor #(
  parameter int NCH         = 4,
  parameter int WINDOW      = 1024,
  parameter int CNT_W       = 11,
  parameter int MIN_EDGES   = 16,
  parameter int MAX_EDGES   = 512,
  parameter int ACQ_WIN     = 2,
  parameter int LOSS_WIN    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       tog_in,
  input  logic [NCH-1:0]       ch_en,
  output logic [NCH-1:0]       toggling,
  output logic [NCH-1:0]       too_fast,
  output logic [NCH-1:0]       lost_pulse,
  output logic [NCH*CNT_W-1:0] edge_count,
  output logic                 window_done
);

  localparam int WIN_W   = (WINDOW < 2) ? 1 : $clog2(WINDOW);
  localparam int MASK_N  = SYNC_STAGES + 1;
  localparam int MASK_W  = $clog2(MASK_N + 1);
  localparam int HYS_MAX = (ACQ_WIN > LOSS_WIN) ? ACQ_WIN : LOSS_WIN;
  localparam int HYS_W   = (HYS_MAX < 2) ? 1 : $clog2(HYS_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_EDGES);
  localparam logic [HYS_W-1:0] ACQ_TOP = HYS_W'(ACQ_WIN - 1);
  localparam logic [HYS_W-1:0] LOS_TOP = HYS_W'(LOSS_WIN - 1);
  localparam logic [WIN_W-1:0] WIN_TOP = WIN_W'(WINDOW - 1);

  // The per-channel FSM state bit is also the toggling output.
  typedef enum logic {DOWN = 1'b0, UP = 1'b1} ch_state_t;

  logic [SYNC_STAGES-1:0] sync_q [NCH];
  logic [NCH-1:0]         prev_q;
  logic [MASK_W-1:0]      mask_q;
  logic [WIN_W-1:0]       win_q;
  logic [CNT_W-1:0]       cnt_q  [NCH];
  logic [CNT_W-1:0]       ecnt_q [NCH];
  logic [HYS_W-1:0]       acq_q  [NCH];
  logic [HYS_W-1:0]       loss_q [NCH];
  ch_state_t              state_q [NCH];
  logic [NCH-1:0]         fast_q;
  logic [NCH-1:0]         lost_q;
  logic                   done_q;

  logic [CNT_W-1:0]       cnt_inc [NCH];
  logic [CNT_W-1:0]       cnt_d   [NCH];
  logic [CNT_W-1:0]       ecnt_d  [NCH];
  logic [HYS_W-1:0]       acq_d   [NCH];
  logic [HYS_W-1:0]       loss_d  [NCH];
  ch_state_t              state_d [NCH];
  logic [NCH-1:0]         fast_d;
  logic [NCH-1:0]         lost_d;
  logic [NCH-1:0]         good;
  logic                   edge_ok;
  logic                   term;

  // Edges are ignored until the synchronizer and prev flop hold real input samples.
  assign edge_ok = (mask_q == MASK_W'(MASK_N));
  assign term    = (win_q == WIN_TOP);

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_inc[i] = cnt_q[i];
      if (edge_ok && (sync_q[i][SYNC_STAGES-1] ^ prev_q[i]) && (cnt_q[i] != CNT_MAX))
        cnt_inc[i] = cnt_q[i] + 1'b1;
      good[i] = (cnt_inc[i] >= MIN_C) && (cnt_inc[i] <= MAX_C);
    end
  end

  always_comb begin
    fast_d = fast_q;
    lost_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      acq_d[i]   = acq_q[i];
      loss_d[i]  = loss_q[i];
      cnt_d[i]   = cnt_inc[i];
      ecnt_d[i]  = ecnt_q[i];
      if (!ch_en[i]) begin
        state_d[i] = DOWN;
        acq_d[i]   = '0;
        loss_d[i]  = '0;
        cnt_d[i]   = '0;
        ecnt_d[i]  = '0;
        fast_d[i]  = 1'b0;
      end else if (term) begin
        cnt_d[i]  = '0;
        ecnt_d[i] = cnt_inc[i];
        fast_d[i] = (cnt_inc[i] > MAX_C);
        case (state_q[i])
          DOWN: begin
            if (!good[i]) begin
              acq_d[i] = '0;
            end else if (acq_q[i] >= ACQ_TOP) begin
              state_d[i] = UP;
              acq_d[i]   = '0;
              loss_d[i]  = '0;
            end else begin
              acq_d[i] = acq_q[i] + 1'b1;
            end
          end
          UP: begin
            if (good[i]) begin
              loss_d[i] = '0;
            end else if (loss_q[i] >= LOS_TOP) begin
              state_d[i] = DOWN;
              loss_d[i]  = '0;
              acq_d[i]   = '0;
              lost_d[i]  = 1'b1;
            end else begin
              loss_d[i] = loss_q[i] + 1'b1;
            end
          end
          default: state_d[i] = DOWN;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      mask_q <= '0;
      win_q  <= '0;
      fast_q <= '0;
      lost_q <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        sync_q[i]  <= '0;
        cnt_q[i]   <= '0;
        ecnt_q[i]  <= '0;
        acq_q[i]   <= '0;
        loss_q[i]  <= '0;
        state_q[i] <= DOWN;
      end
    end else begin
      if (!edge_ok) mask_q <= mask_q + 1'b1;
      win_q  <= term ? '0 : win_q + 1'b1;
      fast_q <= fast_d;
      lost_q <= lost_d;
      done_q <= term;
      for (int i = 0; i < NCH; i++) begin
        sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], tog_in[i]};
        prev_q[i]  <= sync_q[i][SYNC_STAGES-1];
        cnt_q[i]   <= cnt_d[i];
        ecnt_q[i]  <= ecnt_d[i];
        acq_q[i]   <= acq_d[i];
        loss_q[i]  <= loss_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  always_comb begin
    edge_count = '0;
    toggling   = '0;
    for (int i = 0; i < NCH; i++) begin
      edge_count[i*CNT_W +: CNT_W] = ecnt_q[i];
      toggling[i] = (state_q[i] == UP);
    end
  end

  assign too_fast    = fast_q;
  assign lost_pulse  = lost_q;
  assign window_done = done_q;

endmodule

// File: tb/tb_clk_activity_monitor.sv
// Bench for clk_activity_monitor: per-window stimulus rows with a scoreboard queue of expected
// window results, plus hand sequences for disable, reset and held-high input.
module tb_clk_activity_monitor;

  localparam int NCH    = 2;
  localparam int WINDOW = 100;
  localparam int CNT_W  = 7;
  localparam int EXP_W  = 24;
  localparam int NROWS  = 17;

  // Handshake-free block: outputs are sampled on the falling edge, inputs change there too.
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tog0 = 1'b0;
  logic              tog1 = 1'b0;
  logic [NCH-1:0]    tog_in;
  logic [NCH-1:0]    ch_en = '0;
  logic [NCH-1:0]    toggling;
  logic [NCH-1:0]    too_fast;
  logic [NCH-1:0]    lost_pulse;
  logic [NCH*CNT_W-1:0] edge_count;
  logic              window_done;

  int per0 = 0;
  int per1 = 0;
  int tests = 0;
  int fails = 0;

  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    int p0;
    int p1;
    logic [1:0] en;
    int c0;
    int c1;
    int tol;
    logic [1:0] tog;
    logic [1:0] fast;
    logic [1:0] lost;
  } vec_t;

  vec_t tbl [NROWS];

  assign tog_in = {tog1, tog0};

  clk_activity_monitor #(
    .NCH(NCH), .WINDOW(WINDOW), .CNT_W(CNT_W), .MIN_EDGES(10), .MAX_EDGES(30),
    .ACQ_WIN(2), .LOSS_WIN(2), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .tog_in(tog_in), .ch_en(ch_en),
    .toggling(toggling), .too_fast(too_fast), .lost_pulse(lost_pulse),
    .edge_count(edge_count), .window_done(window_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  // per-channel toggle generators: period>0 toggles every period clk, 0 holds, <0 drives high
  initial begin : gen0
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (per0 < 0) tog0 = 1'b1;
      else if (per0 > 0) begin
        c++;
        if (c >= per0) begin c = 0; tog0 = ~tog0; end
      end
    end
  end

  initial begin : gen1
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (per1 < 0) tog1 = 1'b1;
      else if (per1 > 0) begin
        c++;
        if (c >= per1) begin c = 0; tog1 = ~tog1; end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp, input int tol);
    tests++;
    if (act < exp - tol || act > exp + tol) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  // Drive one window of stimulus, queue its expected result, compare at window_done.
  task automatic apply_window(input vec_t v, input string tag);
    logic [EXP_W-1:0] e;
    bit got;
    per0  = v.p0;
    per1  = v.p1;
    ch_en = v.en;
    exp_q.push_back({4'(v.tol), 7'(v.c1), 7'(v.c0), v.lost, v.fast, v.tog});
    got = 0;
    for (int k = 0; k < WINDOW + 20; k++) begin
      @(negedge clk);
      if (window_done) begin got = 1; break; end
    end
    e = exp_q.pop_front();
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s window_done timeout: got 0, want 1", tag);
      return;
    end
    check($sformatf("%s toggling", tag), int'(toggling), int'(e[1:0]), 0);
    check($sformatf("%s too_fast", tag), int'(too_fast), int'(e[3:2]), 0);
    check($sformatf("%s lost_pulse", tag), int'(lost_pulse), int'(e[5:4]), 0);
    check($sformatf("%s count0", tag), int'(edge_count[0 +: CNT_W]), int'(e[12:6]), int'(e[23:20]));
    check($sformatf("%s count1", tag), int'(edge_count[CNT_W +: CNT_W]), int'(e[19:13]), int'(e[23:20]));
    @(negedge clk);
    check($sformatf("%s lost_pulse+1", tag), int'(lost_pulse), 0, 0);
    check($sformatf("%s window_done+1", tag), int'(window_done), 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s toggling", tag), int'(toggling), 0, 0);
    check($sformatf("%s too_fast", tag), int'(too_fast), 0, 0);
    check($sformatf("%s lost_pulse", tag), int'(lost_pulse), 0, 0);
    check($sformatf("%s edge_count", tag), int'(edge_count), 0, 0);
    check($sformatf("%s window_done", tag), int'(window_done), 0, 0);
  endtask

  initial begin
    vec_t v;
    //           p0  p1  en     c0  c1 tol tog    fast   lost
    tbl[0]  = '{ 5,  0, 2'b11, 20,  0, 2, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{ 5,  0, 2'b11, 20,  0, 2, 2'b01, 2'b00, 2'b00};
    tbl[2]  = '{ 5,  0, 2'b11, 20,  0, 2, 2'b01, 2'b00, 2'b00};
    tbl[3]  = '{ 0,  0, 2'b11,  0,  0, 2, 2'b01, 2'b00, 2'b00};
    tbl[4]  = '{ 0,  0, 2'b11,  0,  0, 2, 2'b00, 2'b00, 2'b01};
    tbl[5]  = '{ 0,  2, 2'b11,  0, 50, 2, 2'b00, 2'b10, 2'b00};
    tbl[6]  = '{ 0,  2, 2'b11,  0, 50, 2, 2'b00, 2'b10, 2'b00};
    tbl[7]  = '{ 0,  5, 2'b11,  0, 20, 2, 2'b00, 2'b00, 2'b00};
    tbl[8]  = '{ 0,  0, 2'b11,  0,  0, 2, 2'b00, 2'b00, 2'b00};
    tbl[9]  = '{ 5,  0, 2'b11, 20,  0, 2, 2'b00, 2'b00, 2'b00};
    tbl[10] = '{20,  0, 2'b11,  5,  0, 2, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{ 5,  0, 2'b11, 20,  0, 2, 2'b00, 2'b00, 2'b00};
    tbl[12] = '{20,  0, 2'b11,  5,  0, 2, 2'b00, 2'b00, 2'b00};
    tbl[13] = '{ 5,  0, 2'b11, 20,  0, 2, 2'b00, 2'b00, 2'b00};
    tbl[14] = '{ 5,  0, 2'b11, 20,  0, 2, 2'b01, 2'b00, 2'b00};
    tbl[15] = '{20,  0, 2'b11,  5,  0, 2, 2'b01, 2'b00, 2'b00};
    tbl[16] = '{ 5,  0, 2'b11, 20,  0, 2, 2'b01, 2'b00, 2'b00};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int r = 0; r < NROWS; r++)
      apply_window(tbl[r], $sformatf("row%0d", r));

    // disable ch0 mid-window while UP: cleared next cycle, no lost pulse
    repeat (40) @(negedge clk);
    ch_en = 2'b10;
    @(negedge clk);
    check("disable toggling0", int'(toggling[0]), 0, 0);
    check("disable too_fast0", int'(too_fast[0]), 0, 0);
    check("disable count0", int'(edge_count[0 +: CNT_W]), 0, 0);
    check("disable lost_pulse", int'(lost_pulse), 0, 0);
    v = '{5, 0, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00};
    apply_window(v, "disabled");
    v = '{5, 5, 2'b11, 20, 20, 2, 2'b00, 2'b00, 2'b00};
    apply_window(v, "reacq1");
    v = '{5, 5, 2'b11, 20, 20, 2, 2'b11, 2'b00, 2'b00};
    apply_window(v, "reacq2");

    // reset mid-window with both channels UP; ch0 held high through reset
    per0 = -1;
    repeat (40) @(negedge clk);
    per1 = 0;
    rst  = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    v = '{-1, 0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00};
    apply_window(v, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
